// File: rtl/serial_subtractor_ctrl_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB_SIGNED_OVF_EN is defined.
interface serial_subtractor_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf;
`endif

  // Requester side
  modport master (
    output start, A, B, Bin,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    input  ovf,
`endif
    input  ready, busy, done, Diff, Bout
  );

  // Subtractor side
  modport slave (
    input  start, A, B, Bin,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output ovf,
`endif
    output ready, busy, done, Diff, Bout
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_subtractor cell reused LSB-first, one bit per clock.
// Optional signed overflow flag enabled by defining SERIAL_SUB_SIGNED_OVF_EN.

// One-bit full subtractor: d = a - b - bin, bout = borrow.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_subtractor_ctrl_if.slave   bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic             borrow;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             cell_d;
  logic             cell_bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf_q;
`endif

  // The single arithmetic cell; fed by operand LSBs and the recirculated borrow
  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Sequencer, operand/result shift registers and handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      borrow  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh    <= bus.A;
            b_sh    <= bus.B;
            borrow  <= bus.Bin;
            cnt     <= '0;
            state   <= SHIFT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          diff_sh <= {cell_d, diff_sh[WIDTH-1:1]};
          borrow  <= cell_bout;
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            // Operand LSBs now hold the captured MSBs; cell_d is the result MSB
            ovf_q  <= (a_sh[0] != b_sh[0]) && (cell_d != a_sh[0]);
`endif
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.Diff  = diff_sh;
  assign bus.Bout  = borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed self-checking bench for serial_subtractor_ctrl at WIDTH=8.
// Overflow checks run only when SERIAL_SUB_SIGNED_OVF_EN is defined.
module tb_serial_subtractor_ctrl;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  serial_subtractor_ctrl_if #(.WIDTH(WIDTH)) ifc ();

  serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for done (bounded); returns cycles since the last posedge consumed, 0 on timeout
  task automatic wait_done(output int lat);
    bit found;
    lat   = 0;
    found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(posedge clk); #1;
      if (ifc.done) begin
        found = 1;
        lat   = i;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb);
    int lat;
    @(negedge clk);
    ifc.start = 1'b1; ifc.A = a; ifc.B = b; ifc.Bin = bin;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'd8);
    check_eq({tag, "_diff"}, 32'(ifc.Diff), 32'(ed));
    check_eq({tag, "_bout"}, 32'(ifc.Bout), 32'(eb));
    check_eq({tag, "_ready_in_done"}, 32'(ifc.ready), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_ready_after"}, 32'(ifc.ready), 32'd1);
    check_eq({tag, "_done_one_cycle"}, 32'(ifc.done), 32'd0);
    check_eq({tag, "_diff_hold"}, 32'(ifc.Diff), 32'(ed));
  endtask

  initial begin
    int lat;
    int ready_hi;
    int done_seen;
    int t_done [3];
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vbin [3];
    logic [7:0] vd [3];
    logic       vbo [3];

    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    ifc.start = 1'b0; ifc.A = '0; ifc.B = '0; ifc.Bin = 1'b0;
    #12;
    check_eq("rst_ready", 32'(ifc.ready), 32'd1);
    check_eq("rst_busy",  32'(ifc.busy),  32'd0);
    check_eq("rst_done",  32'(ifc.done),  32'd0);
    check_eq("rst_diff",  32'(ifc.Diff),  32'd0);
    check_eq("rst_bout",  32'(ifc.Bout),  32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check_eq("rst_ovf",   32'(ifc.ovf),   32'd0);
`endif
    @(negedge clk); rst = 1'b0;

    run_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    run_op("under", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op("bin",   8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);

    // Start raised during SHIFT and DONE must be ignored
    @(negedge clk);
    ifc.start = 1'b1; ifc.A = 8'h5A; ifc.B = 8'h3C; ifc.Bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    ready_hi = 0; lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (ifc.done) lat = i;
      else if (ifc.ready) ready_hi++;
      if (i == 2) begin
        @(negedge clk);
        ifc.start = 1'b1; ifc.A = 8'hFF; ifc.B = 8'h00;
      end
    end
    check_eq("ign_latency", 32'(lat), 32'd8);
    check_eq("ign_ready_in_shift", 32'(ready_hi), 32'd0);
    check_eq("ign_ready_in_done", 32'(ifc.ready), 32'd0);
    check_eq("ign_diff", 32'(ifc.Diff), 32'h1E);
    @(negedge clk); ifc.start = 1'b0;
    @(posedge clk); #1;
    check_eq("ign_idle_ready", 32'(ifc.ready), 32'd1);
    check_eq("ign_not_started", 32'(ifc.busy), 32'd0);
    check_eq("ign_diff_hold", 32'(ifc.Diff), 32'h1E);

    // Back-to-back with start held high
    va[0] = 8'h5A; vb[0] = 8'h3C; vbin[0] = 1'b0; vd[0] = 8'h1E; vbo[0] = 1'b0;
    va[1] = 8'h00; vb[1] = 8'h01; vbin[1] = 1'b0; vd[1] = 8'hFF; vbo[1] = 1'b1;
    va[2] = 8'h3C; vb[2] = 8'hC3; vbin[2] = 1'b1; vd[2] = 8'h78; vbo[2] = 1'b1;
    @(negedge clk);
    ifc.start = 1'b1; ifc.A = va[0]; ifc.B = vb[0]; ifc.Bin = vbin[0];
    for (int k = 0; k < 3; k++) begin
      wait_done(lat);
      t_done[k] = cyc;
      check_eq($sformatf("b2b%0d_diff", k), 32'(ifc.Diff), 32'(vd[k]));
      check_eq($sformatf("b2b%0d_bout", k), 32'(ifc.Bout), 32'(vbo[k]));
      @(negedge clk);
      if (k < 2) begin
        ifc.A = va[k+1]; ifc.B = vb[k+1]; ifc.Bin = vbin[k+1];
      end else begin
        ifc.start = 1'b0;
      end
    end
    check_eq("b2b_period01", 32'(t_done[1] - t_done[0]), 32'd10);
    check_eq("b2b_period12", 32'(t_done[2] - t_done[1]), 32'd10);
    @(posedge clk); @(posedge clk);

    // Asynchronous reset on the 4th SHIFT cycle
    @(negedge clk);
    ifc.start = 1'b1; ifc.A = 8'hC3; ifc.B = 8'h3C; ifc.Bin = 1'b0;
    @(posedge clk);
    @(negedge clk); ifc.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_ready", 32'(ifc.ready), 32'd1);
    check_eq("arst_busy",  32'(ifc.busy),  32'd0);
    check_eq("arst_done",  32'(ifc.done),  32'd0);
    check_eq("arst_diff",  32'(ifc.Diff),  32'd0);
    check_eq("arst_bout",  32'(ifc.Bout),  32'd0);
    @(negedge clk); rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ifc.done) done_seen++;
    end
    check_eq("arst_no_done", 32'(done_seen), 32'd0);
    run_op("post_rst", 8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0);

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    run_op("ovf_pos", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    check_eq("ovf_set", 32'(ifc.ovf), 32'd1);
    run_op("ovf_neg", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    check_eq("ovf_clr", 32'(ifc.ovf), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
